// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_pkg
// Description : Shared types and constants for the add_seq_ctrl sequencer:
//               FSM state encoding, uio bit positions and output-enable mask.
// Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Bit positions inside uio_in / uio_out
    localparam int IN_VALID_B  = 0;
    localparam int IN_READY_B  = 1;
    localparam int OUT_VALID_B = 2;
    localparam int OUT_ACK_B   = 3;
    localparam int CARRY_B     = 4;
    localparam int ERR_B       = 5;

    // Pins this block drives on the bidirectional bus
    localparam logic [7:0] UIO_OE_MASK = 8'h36;

endpackage
`default_nettype wire

// File: rtl/add_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_timer
// Description : Idle-cycle counter for the LOAD_B timeout. Pulses expire on
//               the increment that would complete TIMEOUT_CYCLES idle cycles.
//               TIMEOUT_CYCLES == 0 disables expiry entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [CNT_W-1:0] r_cnt;

    // Counter: clear wins over increment so the expiring cycle also resets it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            assign expire = (r_cnt == c_LAST) && inc;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_ctrl
// Description : Sequencer for the 8-bit adder behind the TT pins. Loads
//               operand A then B over a valid/ready handshake on uio, adds
//               them, and holds the result on uo_out until out_ack. A stalled
//               LOAD_B aborts with a sticky err flag after TIMEOUT_CYCLES.
//               Optional macro ADD_SAT_EN: saturate result to 8'hFF on carry.
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_err;

    logic       w_in_valid;
    logic       w_out_ack;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_take_a;
    logic       w_take_b;
    logic       w_inc;
    logic       w_clr;
    logic       w_expire;
    logic [8:0] w_sum;
    logic [7:0] w_result_next;
    logic       w_unused_uio;

    assign w_in_valid   = uio_in[IN_VALID_B];
    assign w_out_ack    = uio_in[OUT_ACK_B];
    assign w_unused_uio = &{1'b0, uio_in[7:4], uio_in[2:1]};

    // Handshake flags come from state alone, never from inputs
    assign w_in_ready  = (r_state == IDLE) || (r_state == LOAD_B);
    assign w_out_valid = (r_state == HOLD);

    assign w_take_a = ena && w_in_valid && (r_state == IDLE);
    assign w_take_b = ena && w_in_valid && (r_state == LOAD_B);

    // Count only enabled, valid-less LOAD_B cycles; clear whenever LOAD_B is left
    assign w_inc = ena && (r_state == LOAD_B) && !w_in_valid;
    assign w_clr = ena && (r_state == LOAD_B) && (w_in_valid || w_expire);

    add_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_inc),
        .expire (w_expire)
    );

    assign w_sum = {1'b0, r_op_a} + {1'b0, r_op_b};

`ifdef ADD_SAT_EN
    assign w_result_next = w_sum[8] ? 8'hFF : w_sum[7:0];
`else
    assign w_result_next = w_sum[7:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; ena low holds the current state
    always_comb begin
        w_next = r_state;
        if (ena) begin
            case (r_state)
                IDLE:    if (w_in_valid) w_next = LOAD_B;
                LOAD_B: begin
                    if (w_in_valid)    w_next = EXEC;
                    else if (w_expire) w_next = IDLE;
                end
                EXEC:    w_next = HOLD;
                HOLD:    if (w_out_ack) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Operand, result and status registers; all frozen while ena is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else if (ena) begin
            if (w_take_a) begin
                r_op_a <= ui_in;
                r_err  <= 1'b0;
            end
            if (w_take_b) begin
                r_op_b <= ui_in;
            end
            if (w_expire) begin
                r_err <= 1'b1;
            end
            if (r_state == EXEC) begin
                r_result <= w_result_next;
                r_carry  <= w_sum[8];
            end
        end
    end

    // Output pin assembly; undriven uio bits read 0
    always_comb begin
        uio_out              = '0;
        uio_out[IN_READY_B]  = w_in_ready;
        uio_out[OUT_VALID_B] = w_out_valid;
        uio_out[CARRY_B]     = r_carry;
        uio_out[ERR_B]       = r_err;
    end

    assign uo_out = r_result;
    assign uio_oe = UIO_OE_MASK;

endmodule
`default_nettype wire
